// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline front end:
// fetch FSM states, redirect select codes, IF output bundle.
package mips_pipe_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [1:0] REDIR_NONE   = 2'd0;
    localparam logic [1:0] REDIR_BRANCH = 2'd1;
    localparam logic [1:0] REDIR_JUMP   = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_out_t;

    localparam if_out_t IF_BUBBLE = '{
        instr: NOP_INSTR,
        pc4:   32'h0,
        valid: 1'b0
    };

    // Branch comes from the older instruction in EX, so it beats jump.
    function automatic logic [1:0] redir_sel(
        input logic br,
        input logic jmp
    );
        logic [1:0] sel;
        sel = REDIR_NONE;
        if (br) begin
            sel = REDIR_BRANCH;
        end else if (jmp) begin
            sel = REDIR_JUMP;
        end
        return sel;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc4} holding buffer used while ID stalls
// after a response has already been accepted from memory.
module fetch_skid_buf
    import mips_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        full_o
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            full_q  <= 1'b0;
        end else if (clear_i) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            full_q  <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            full_q  <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign full_o  = full_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// IF stage: owns the PC, runs the imem request handshake and
// feeds the IF/ID register, handling stall, redirect and drain.
module mips_fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] IF_instr,
    output logic [31:0] IF_pc4,
    output logic        IF_valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    if_out_t      out_q, out_d;

    logic [1:0]   sel;
    logic         redirect;
    logic [31:0]  tgt;
    logic [31:0]  pc_inc;

    logic         buf_load;
    logic         buf_clear;
    logic [31:0]  buf_instr;
    logic [31:0]  buf_pc4;
    logic         buf_full;

    assign pc_inc    = pc_q + PC_STEP;
    assign imem_req  = !reset && (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? pend_q : pc_q;

    always_comb begin
        sel      = redir_sel(branch_taken, jump);
        redirect = (sel != REDIR_NONE);
        tgt      = pc_q;
        unique case (1'b1)
            (sel == REDIR_BRANCH): tgt = word_align(branch_target);
            (sel == REDIR_JUMP):   tgt = word_align(jump_target);
            default:               tgt = pc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        out_d     = out_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        if (redirect) begin
            pc_d      = tgt;
            out_d     = IF_BUBBLE;
            buf_clear = 1'b1;
            // An unanswered request (fetch or drain) must be seen
            // through on its original address before refetching.
            if (state_q != HOLD && !imem_valid) begin
                state_d = DRAIN;
                pend_d  = imem_addr;
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_valid) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            buf_load = 1'b1;
                            state_d  = HOLD;
                        end else begin
                            out_d = '{
                                instr: imem_rdata,
                                pc4:   pc_inc,
                                valid: 1'b1
                            };
                        end
                    end else if (!stall) begin
                        out_d = IF_BUBBLE;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        out_d = '{
                            instr: buf_instr,
                            pc4:   buf_pc4,
                            valid: 1'b1
                        };
                        buf_clear = 1'b1;
                        state_d   = FETCH;
                    end
                end
                DRAIN: begin
                    out_d = IF_BUBBLE;
                    if (imem_valid) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= word_align(RESET_PC);
            pend_q  <= word_align(RESET_PC);
            out_q   <= IF_BUBBLE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (imem_rdata),
        .pc4_i   (pc_inc),
        .instr_o (buf_instr),
        .pc4_o   (buf_pc4),
        .full_o  (buf_full)
    );

    assign IF_instr = out_q.instr;
    assign IF_pc4   = out_q.pc4;
    assign IF_valid = out_q.valid;

    a_bubble_is_nop: assert property (
        @(posedge clk) !out_q.valid |-> (out_q.instr == NOP_INSTR)
    );

    a_hold_needs_buf: assert property (
        @(posedge clk) disable iff (reset)
        (state_q == HOLD) |-> buf_full
    );

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Randomised bench for mips_fetch_stage with a queue-based
// reference model, a variable-latency memory and directed pins.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] IF_instr;
    logic [31:0] IF_pc4;
    logic        IF_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic        w_valid;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mips_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .IF_instr      (IF_instr),
        .IF_pc4        (IF_pc4),
        .IF_valid      (IF_valid)
    );

    // Zero-wait memory returning address as data, PC near wrap.
    mips_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk           (clk),
        .reset         (reset),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .jump          (1'b0),
        .jump_target   (32'h0),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_rdata    (w_addr),
        .imem_valid    (w_req),
        .IF_instr      (w_instr),
        .IF_pc4        (w_pc4),
        .IF_valid      (w_valid)
    );

    // Reference model: fetch pointer, optional drain address,
    // a queue of accepted-but-unconsumed words, and the IF/ID view.
    logic [31:0] m_pc;
    logic [31:0] m_daddr;
    bit          m_drain;
    logic [63:0] m_held[$];
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;

    int          mem_wait;
    int          mem_lat;
    int          force_lat;
    logic [31:0] dx;

    function automatic bit m_req_f();
        return !reset && (m_held.size() == 0);
    endfunction

    function automatic logic [31:0] m_addr_f();
        return m_drain ? m_daddr : m_pc;
    endfunction

    function automatic int pick_lat();
        if (force_lat >= 0) return force_lat;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic drive_mem();
        imem_valid = m_req_f() && (mem_wait >= mem_lat);
        imem_rdata = imem_valid ? (m_addr_f() ^ dx) : 32'h0BAD_0BAD;
    endtask

    task automatic model_update();
        bit          req;
        bit          done;
        logic [31:0] addr;
        logic [31:0] tgt;
        req  = m_req_f();
        addr = m_addr_f();
        done = req && imem_valid;
        if (reset || done) begin
            mem_wait = 0;
            mem_lat  = pick_lat();
        end else if (req) begin
            mem_wait++;
        end
        if (reset) begin
            m_pc    = 32'h0;
            m_drain = 1'b0;
            m_held.delete();
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end else if (branch_taken || jump) begin
            tgt = branch_taken ? branch_target : jump_target;
            tgt[1:0] = 2'b00;
            if (req && !imem_valid) begin
                m_drain = 1'b1;
                m_daddr = addr;
            end else begin
                m_drain = 1'b0;
            end
            m_pc = tgt;
            m_held.delete();
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end else if (m_drain) begin
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            if (imem_valid) m_drain = 1'b0;
        end else if (m_held.size() != 0) begin
            if (!stall) begin
                {m_instr, m_pc4} = m_held.pop_front();
                m_valid = 1'b1;
            end
        end else if (imem_valid) begin
            if (stall) begin
                m_held.push_back({imem_rdata, m_pc + 32'd4});
            end else begin
                m_instr = imem_rdata;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end
    endtask

    task automatic compare();
        chk("IF_valid", {31'h0, IF_valid}, {31'h0, m_valid});
        chk("IF_instr", IF_instr, m_instr);
        chk("IF_pc4", IF_pc4, m_pc4);
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_req_f()});
        if (m_req_f()) chk("imem_addr", imem_addr, m_addr_f());
    endtask

    task automatic step();
        drive_mem();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        imem_valid    = 1'b0;
        imem_rdata    = 32'h0;
        mem_wait      = 0;
        mem_lat       = 0;
        force_lat     = 0;
        dx            = 32'h0;
        m_drain       = 1'b0;
        m_pc          = 32'h0;
        m_daddr       = 32'h0;

        @(negedge clk);
        step();
        step();
        chk("rst_valid", {31'h0, IF_valid}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_addr", imem_addr, 32'h0);
        chk("w_rst_addr", w_addr, 32'hFFFF_FFFC);

        // 0-wait, address as data
        step();
        chk("seq_pc4_0", IF_pc4, 32'd4);
        chk("seq_val_0", {31'h0, IF_valid}, 32'h1);
        chk("w_pc4_wrap", w_pc4, 32'h0);
        chk("w_instr", w_instr, 32'hFFFF_FFFC);
        chk("w_addr2", w_addr, 32'h0);
        step();
        chk("seq_pc4_1", IF_pc4, 32'd8);
        step();
        chk("seq_pc4_2", IF_pc4, 32'd12);
        chk("seq_instr_2", IF_instr, 32'd8);
        step();
        chk("seq_instr_3", IF_instr, 32'hC);

        // stall while the 0x10 response lands
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", IF_instr, 32'hC);
        end
        chk("stall_noreq", {31'h0, imem_req}, 32'h0);
        stall = 1'b0;
        step();
        chk("rel_instr", IF_instr, 32'h10);
        chk("rel_pc4", IF_pc4, 32'h14);
        step();
        chk("rel_next", IF_instr, 32'h14);

        // branch during a 3-cycle memory wait
        mem_lat       = 3;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        step();
        branch_taken = 1'b0;
        chk("drn_addr0", imem_addr, 32'h18);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("drn_addr", imem_addr, 32'h18);
            chk("drn_valid", {31'h0, IF_valid}, 32'h0);
        end
        step();
        chk("drn_newaddr", imem_addr, 32'h200);
        chk("drn_valid_end", {31'h0, IF_valid}, 32'h0);
        step();
        chk("br_first", IF_instr, 32'h200);
        chk("br_first_pc4", IF_pc4, 32'h204);

        // branch beats jump, flush beats stall
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        jump          = 1'b1;
        jump_target   = 32'h300;
        stall         = 1'b1;
        step();
        branch_taken = 1'b0;
        jump         = 1'b0;
        stall        = 1'b0;
        chk("prio_addr", imem_addr, 32'h100);
        chk("prio_valid", {31'h0, IF_valid}, 32'h0);

        // reset in the middle of a drain
        mem_lat       = 5;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        step();
        chk("mid_drain_addr", imem_addr, 32'h100);
        force_lat = -1;
        reset     = 1'b1;
        step();
        chk("mid_rst_pc4", IF_pc4, 32'h0);
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        reset = 1'b0;
        #1;
        chk("mid_rst_req1", {31'h0, imem_req}, 32'h1);
        chk("mid_rst_addr", imem_addr, 32'h0);

        // randomised traffic
        dx = 32'hDEAD_BEEF;
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 199) == 0);
            stall         = ($urandom_range(0, 9) < 3);
            branch_taken  = ($urandom_range(0, 19) == 0);
            jump          = ($urandom_range(0, 19) == 0);
            branch_target = $urandom;
            jump_target   = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
